// File: rtl/ram_burst_bridge_pkg.sv
// ram_burst_bridge_pkg: shared FSM encoding and width helper for the RAM burst bridge
package ram_burst_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  function automatic int ofs_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/ram_burst_bridge_if.sv
// ram_burst_bridge_if: cache-side request bus and RAM-side command/response bus of the bridge
interface ram_burst_bridge_if
  import ram_burst_bridge_pkg::*;
#(
  parameter int TAG_WIDTH      = 8,
  parameter int INDEX_WIDTH    = 4,
  parameter int STR_WIDTH      = 128,
  parameter int RAM_WORD_WIDTH = 8
);
  localparam int WORDS  = STR_WIDTH / RAM_WORD_WIDTH;
  localparam int RAM_AW = TAG_WIDTH + INDEX_WIDTH + ofs_width(WORDS);
  logic                      cache_ram_aval;
  logic                      cache_ram_rnw;
  logic [TAG_WIDTH-1:0]      tag;
  logic [INDEX_WIDTH-1:0]    index;
  logic [STR_WIDTH-1:0]      wdata;
  logic [WORDS-1:0]          wmask;
  logic                      cache_ram_busy;
  logic                      cache_ram_ack;
  logic                      cache_ram_err;
  logic [STR_WIDTH-1:0]      rdata;
  logic [RAM_AW-1:0]         ram_addr;
  logic                      ram_aval;
  logic                      ram_rnw;
  logic [RAM_WORD_WIDTH-1:0] ram_wdata;
  logic                      ram_ready;
  logic                      ram_ack;
  logic [RAM_WORD_WIDTH-1:0] ram_rdata;
  modport master (
    output cache_ram_aval, cache_ram_rnw, tag, index, wdata, wmask, ram_ready, ram_ack, ram_rdata,
    input  cache_ram_busy, cache_ram_ack, cache_ram_err, rdata, ram_addr, ram_aval, ram_rnw, ram_wdata
  );
  modport slave (
    input  cache_ram_aval, cache_ram_rnw, tag, index, wdata, wmask, ram_ready, ram_ack, ram_rdata,
    output cache_ram_busy, cache_ram_ack, cache_ram_err, rdata, ram_addr, ram_aval, ram_rnw, ram_wdata
  );
endinterface

// File: rtl/ram_burst_bridge_line_buffer.sv
// ram_burst_bridge_line_buffer: line register with full-line load, single-word write and word read mux
module ram_burst_bridge_line_buffer #(
  parameter int STR_WIDTH  = 128,
  parameter int WORD_WIDTH = 8,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [STR_WIDTH-1:0]  line_i,
  input  logic                  wr_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [WORD_WIDTH-1:0] wr_word_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [STR_WIDTH-1:0]  line_o
);
  logic [STR_WIDTH-1:0] line_q, line_d;
  // whole-line load wins over a single-word update
  always_comb begin
    line_d = line_q;
    if (load_i) line_d = line_i;
    else if (wr_i) line_d[wr_idx_i*WORD_WIDTH +: WORD_WIDTH] = wr_word_i;
  end
  // line storage
  always_ff @(posedge clk or posedge rst)
    if (rst) line_q <= '0;
    else line_q <= line_d;
  assign word_o = line_q[rd_idx_i*WORD_WIDTH +: WORD_WIDTH];
  assign line_o = line_q;
endmodule

// File: rtl/ram_burst_bridge.sv
// ram_burst_bridge: splits a cache line transfer into pipelined RAM word commands with in-order responses
module ram_burst_bridge
  import ram_burst_bridge_pkg::*;
#(
  parameter int TAG_WIDTH       = 8,
  parameter int INDEX_WIDTH     = 4,
  parameter int STR_WIDTH       = 128,
  parameter int RAM_WORD_WIDTH  = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic clk,
  input logic rst,
  ram_burst_bridge_if.slave bus
);
  localparam int WORDS = STR_WIDTH / RAM_WORD_WIDTH;
  localparam int OFS_W = ofs_width(WORDS);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t                 state_q, state_d;
  logic                   rnw_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [WORDS-1:0]       rem_q, rem_d, rem_nx;
  logic [OFS_W-1:0]       ofs, rx_q, rx_d;
  logic [OUT_W-1:0]       out_q, out_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   err_q, err_d;
  logic                   start, acc, rsp, active, last, tmo_hit;
  assign start   = state_q == IDLE && bus.cache_ram_aval;
  assign acc     = bus.ram_aval && bus.ram_ready;
  assign rsp     = bus.ram_ack && out_q != '0;
  assign active  = state_q == ISSUE || state_q == WAIT;
  assign rem_nx  = rem_q & ~(WORDS'(1) << ofs);
  assign last    = acc && rem_nx == '0;
  assign tmo_d   = (!active || acc || rsp) ? '0 : (out_q != '0) ? tmo_q + TMO_W'(1) : tmo_q;
  assign tmo_hit = active && tmo_d == TMO_W'(TIMEOUT_CYCLES);
  // offset of the next command: lowest word still pending in the remaining mask
  always_comb begin
    ofs = '0;
    for (int i = WORDS - 1; i >= 0; i--) if (rem_q[i]) ofs = OFS_W'(i);
  end
  // pending-word mask, response offset, outstanding count and error flag
  always_comb begin
    rem_d = start ? (bus.cache_ram_rnw ? '1 : bus.wmask) : tmo_hit ? '0 : acc ? rem_nx : rem_q;
    rx_d  = start ? '0 : (rsp && rnw_q) ? rx_q + OFS_W'(1) : rx_q;
    out_d = tmo_hit ? '0 : out_q + OUT_W'(acc) - OUT_W'(rsp);
    err_d = start ? 1'b0 : tmo_hit ? 1'b1 : err_q;
  end
  // burst sequencing: an empty write mask skips straight to completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start ? IDLE : (bus.cache_ram_rnw || |bus.wmask) ? ISSUE : DONE;
      ISSUE:   state_d = tmo_hit ? DONE : last ? WAIT : ISSUE;
      WAIT:    state_d = (tmo_hit || out_d == '0) ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  // state, counters and the latched request
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      rx_q    <= '0;
      out_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rnw_q   <= 1'b0;
      tag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      rx_q    <= rx_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      if (start) begin
        rnw_q <= bus.cache_ram_rnw;
        tag_q <= bus.tag;
        idx_q <= bus.index;
      end
    end
  // one buffer serves both directions: write line on a write, assembled read line on a read
  ram_burst_bridge_line_buffer #(
    .STR_WIDTH (STR_WIDTH),
    .WORD_WIDTH(RAM_WORD_WIDTH),
    .IDX_W     (OFS_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (start && !bus.cache_ram_rnw),
    .line_i   (bus.wdata),
    .wr_i     (rsp && rnw_q),
    .wr_idx_i (rx_q),
    .wr_word_i(bus.ram_rdata),
    .rd_idx_i (ofs),
    .word_o   (bus.ram_wdata),
    .line_o   (bus.rdata)
  );
  assign bus.cache_ram_busy = state_q != IDLE;
  assign bus.cache_ram_ack  = state_q == DONE;
  assign bus.cache_ram_err  = state_q == DONE && err_q;
  assign bus.ram_aval       = state_q == ISSUE && out_q < OUT_W'(MAX_OUTSTANDING);
  assign bus.ram_rnw        = rnw_q;
  assign bus.ram_addr       = {tag_q, idx_q, ofs};
endmodule

// File: tb/tb_ram_burst_bridge.sv
// tb_ram_burst_bridge: directed checks of two bridges (outstanding limit 4 and 2) against a fixed-latency RAM model
module tb_ram_burst_bridge;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic         c_aval [2];
  logic         c_rnw  [2];
  logic [7:0]   c_tag  [2];
  logic [3:0]   c_idx  [2];
  logic [127:0] c_wdata[2];
  logic [15:0]  c_wmask[2];
  logic         rdy    [2];
  logic         ack_en [2];
  logic         flush  [2];
  logic         o_busy [2];
  logic         o_ack  [2];
  logic         o_err  [2];
  logic         o_aval [2];
  logic [127:0] o_rdata[2];
  logic [15:0]  o_addr [2];
  int           acc_cnt [2];
  logic [15:0]  acc_addr[2][32];
  logic [7:0]   acc_wd  [2][32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_burst_bridge_if bus [2] ();
  ram_burst_bridge dut0 (.clk(clk), .rst(rst), .bus(bus[0]));
  ram_burst_bridge #(.MAX_OUTSTANDING(2)) dut1 (.clk(clk), .rst(rst), .bus(bus[1]));

  for (genvar g = 0; g < 2; g++) begin : m
    int          due_q[$];
    logic [15:0] pa_q[$];
    int          cnt = 0;
    logic [15:0] la [32];
    logic [7:0]  lw [32];
    logic        ack_r = 1'b0;
    logic [7:0]  rd_r = '0;
    assign bus[g].cache_ram_aval = c_aval[g];
    assign bus[g].cache_ram_rnw  = c_rnw[g];
    assign bus[g].tag            = c_tag[g];
    assign bus[g].index          = c_idx[g];
    assign bus[g].wdata          = c_wdata[g];
    assign bus[g].wmask          = c_wmask[g];
    assign bus[g].ram_ready      = rdy[g];
    assign bus[g].ram_ack        = ack_r;
    assign bus[g].ram_rdata      = rd_r;
    assign o_busy[g]   = bus[g].cache_ram_busy;
    assign o_ack[g]    = bus[g].cache_ram_ack;
    assign o_err[g]    = bus[g].cache_ram_err;
    assign o_aval[g]   = bus[g].ram_aval;
    assign o_rdata[g]  = bus[g].rdata;
    assign o_addr[g]   = bus[g].ram_addr;
    assign acc_cnt[g]  = cnt;
    assign acc_addr[g] = la;
    assign acc_wd[g]   = lw;
    // RAM: answers each accepted command LAT cycles later, in order; read word = {offset, ~offset}
    always @(negedge clk) begin
      ack_r = 1'b0;
      rd_r  = '0;
      if (flush[g]) begin
        due_q.delete();
        pa_q.delete();
        cnt = 0;
      end else begin
        if (ack_en[g] && due_q.size() > 0 && due_q[0] <= cyc) begin
          ack_r = 1'b1;
          rd_r  = {pa_q[0][3:0], ~pa_q[0][3:0]};
          void'(due_q.pop_front());
          void'(pa_q.pop_front());
        end
        if (bus[g].ram_aval && bus[g].ram_ready) begin
          due_q.push_back(cyc + LAT);
          pa_q.push_back(bus[g].ram_addr);
          if (cnt < 32) begin
            la[cnt] = bus[g].ram_addr;
            lw[cnt] = bus[g].ram_wdata;
          end
          cnt++;
        end
      end
    end
  end

  function automatic logic [127:0] exp_line();
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[k*8 +: 8] = {4'(k), ~4'(k)};
    return l;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_flush(input int g);
    flush[g] = 1'b1;
    tick();
    flush[g] = 1'b0;
  endtask

  task automatic req(input int g, input logic rnw, input logic [7:0] tg, input logic [3:0] ix,
                     input logic [127:0] wd, input logic [15:0] wm, output int n);
    c_aval[g] = 1'b1; c_rnw[g] = rnw; c_tag[g] = tg; c_idx[g] = ix; c_wdata[g] = wd; c_wmask[g] = wm;
    n = cyc;
    tick();
    c_aval[g] = 1'b0;
  endtask

  task automatic wait_ack(input int g, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (o_ack[g]) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tests++; if (o_busy[0] !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", o_busy[0]); end
    tests++; if (o_ack[0] !== 1'b0 || o_err[0] !== 1'b0) begin fails++; $display("FAIL reset_ack_err: got %b%b expected 00", o_ack[0], o_err[0]); end
    tests++; if (o_aval[0] !== 1'b0 || o_addr[0] !== 16'h0) begin fails++; $display("FAIL reset_ram: got aval %b addr %h expected 0 0000", o_aval[0], o_addr[0]); end
    tests++; if (o_rdata[0] !== 128'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", o_rdata[0]); end
  endtask

  task automatic test_read();
    int n, at, bad;
    do_flush(0);
    req(0, 1'b1, 8'hA5, 4'h3, '0, '0, n);
    wait_ack(0, 40, at);
    tests++; if (at !== n + 19) begin fails++; $display("FAIL read_ack_cycle: got %0d expected %0d", at, n + 19); end
    tests++; if (o_err[0] !== 1'b0) begin fails++; $display("FAIL read_err: got %b expected 0", o_err[0]); end
    tests++; if (o_rdata[0] !== exp_line()) begin fails++; $display("FAIL read_rdata: got %h expected %h", o_rdata[0], exp_line()); end
    tests++; if (acc_cnt[0] !== 16) begin fails++; $display("FAIL read_cmd_count: got %0d expected 16", acc_cnt[0]); end
    bad = 0;
    for (int k = 0; k < 16; k++) if (acc_addr[0][k] !== 16'hA530 + 16'(k)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL read_addr: got %0d wrong addresses expected 0 (first %h)", bad, acc_addr[0][0]); end
    tick();
    tests++; if (o_busy[0] !== 1'b0) begin fails++; $display("FAIL read_busy_after: got %b expected 0", o_busy[0]); end
  endtask

  task automatic test_write_mask();
    int n, at;
    logic [127:0] wd;
    for (int k = 0; k < 16; k++) wd[k*8 +: 8] = 8'h10 + 8'(k);
    do_flush(0);
    req(0, 1'b0, 8'h3C, 4'h9, wd, 16'h8001, n);
    wait_ack(0, 20, at);
    tests++; if (at !== n + 5) begin fails++; $display("FAIL write_ack_cycle: got %0d expected %0d", at, n + 5); end
    tests++; if (acc_cnt[0] !== 2) begin fails++; $display("FAIL write_cmd_count: got %0d expected 2", acc_cnt[0]); end
    tests++; if (acc_addr[0][0] !== 16'h3C90 || acc_addr[0][1] !== 16'h3C9F) begin fails++; $display("FAIL write_addr: got %h %h expected 3c90 3c9f", acc_addr[0][0], acc_addr[0][1]); end
    tests++; if (acc_wd[0][0] !== 8'h10 || acc_wd[0][1] !== 8'h1F) begin fails++; $display("FAIL write_data: got %h %h expected 10 1f", acc_wd[0][0], acc_wd[0][1]); end
    tests++; if (o_err[0] !== 1'b0) begin fails++; $display("FAIL write_err: got %b expected 0", o_err[0]); end
    tick();
  endtask

  task automatic test_empty_mask();
    int n, at;
    do_flush(0);
    req(0, 1'b0, 8'h11, 4'h2, 128'hFFFF, 16'h0, n);
    wait_ack(0, 10, at);
    tests++; if (at !== n + 1) begin fails++; $display("FAIL empty_ack_cycle: got %0d expected %0d", at, n + 1); end
    tests++; if (o_err[0] !== 1'b0) begin fails++; $display("FAIL empty_err: got %b expected 0", o_err[0]); end
    tests++; if (acc_cnt[0] !== 0) begin fails++; $display("FAIL empty_cmd_count: got %0d expected 0", acc_cnt[0]); end
    tick();
  endtask

  task automatic test_outstanding();
    int n, at;
    do_flush(1);
    ack_en[1] = 1'b0;
    req(1, 1'b1, 8'h5A, 4'hC, '0, '0, n);
    repeat (10) tick();
    tests++; if (acc_cnt[1] !== 2) begin fails++; $display("FAIL limit_cmd_count: got %0d expected 2", acc_cnt[1]); end
    tests++; if (o_aval[1] !== 1'b0) begin fails++; $display("FAIL limit_aval: got %b expected 0", o_aval[1]); end
    ack_en[1] = 1'b1;
    wait_ack(1, 100, at);
    tests++; if (at < 0) begin fails++; $display("FAIL limit_ack_timeout: got no ack expected ack"); end
    tests++; if (acc_cnt[1] !== 16) begin fails++; $display("FAIL limit_resume_count: got %0d expected 16", acc_cnt[1]); end
    tests++; if (o_rdata[1] !== exp_line() || o_err[1] !== 1'b0) begin fails++; $display("FAIL limit_rdata: got %h err %b expected %h err 0", o_rdata[1], o_err[1], exp_line()); end
    tick();
  endtask

  task automatic test_timeout();
    int n, at;
    do_flush(0);
    ack_en[0] = 1'b0;
    req(0, 1'b1, 8'h77, 4'h1, '0, '0, n);
    wait_ack(0, 400, at);
    tests++; if (at !== n + 260) begin fails++; $display("FAIL tmo_ack_cycle: got %0d expected %0d", at, n + 260); end
    tests++; if (o_err[0] !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b expected 1", o_err[0]); end
    tests++; if (acc_cnt[0] !== 4) begin fails++; $display("FAIL tmo_cmd_count: got %0d expected 4", acc_cnt[0]); end
    tick();
    tests++; if (o_busy[0] !== 1'b0) begin fails++; $display("FAIL tmo_busy_after: got %b expected 0", o_busy[0]); end
    do_flush(0);
    ack_en[0] = 1'b1;
    req(0, 1'b1, 8'h11, 4'h2, '0, '0, n);
    wait_ack(0, 40, at);
    tests++; if (at !== n + 19 || o_err[0] !== 1'b0) begin fails++; $display("FAIL tmo_recover: got cycle %0d err %b expected %0d err 0", at, o_err[0], n + 19); end
    tests++; if (o_rdata[0] !== exp_line()) begin fails++; $display("FAIL tmo_recover_rdata: got %h expected %h", o_rdata[0], exp_line()); end
    tick();
  endtask

  task automatic test_reset_mid_issue();
    int n, at;
    do_flush(0);
    req(0, 1'b1, 8'hA5, 4'h3, '0, '0, n);
    tick();
    tick();
    tests++; if (o_busy[0] !== 1'b1 || o_aval[0] !== 1'b1) begin fails++; $display("FAIL mid_pre_state: got busy %b aval %b expected 1 1", o_busy[0], o_aval[0]); end
    #1 rst = 1'b1;
    #1;
    tests++; if (o_busy[0] !== 1'b0 || o_aval[0] !== 1'b0 || o_ack[0] !== 1'b0) begin fails++; $display("FAIL mid_rst_ctrl: got busy %b aval %b ack %b expected 000", o_busy[0], o_aval[0], o_ack[0]); end
    tests++; if (o_addr[0] !== 16'h0 || o_rdata[0] !== 128'h0) begin fails++; $display("FAIL mid_rst_data: got addr %h rdata %h expected 0", o_addr[0], o_rdata[0]); end
    flush[0] = 1'b1;
    flush[1] = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    flush[0] = 1'b0;
    flush[1] = 1'b0;
    tick();
    tests++; if (o_ack[0] !== 1'b0 || o_busy[0] !== 1'b0) begin fails++; $display("FAIL mid_post_rst: got ack %b busy %b expected 0 0", o_ack[0], o_busy[0]); end
    req(0, 1'b1, 8'h42, 4'h6, '0, '0, n);
    wait_ack(0, 40, at);
    tests++; if (at !== n + 19 || o_err[0] !== 1'b0) begin fails++; $display("FAIL mid_next_req: got cycle %0d err %b expected %0d err 0", at, o_err[0], n + 19); end
    tests++; if (o_rdata[0] !== exp_line()) begin fails++; $display("FAIL mid_next_rdata: got %h expected %h", o_rdata[0], exp_line()); end
    tick();
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      c_aval[g] = 1'b0; c_rnw[g] = 1'b0; c_tag[g] = '0; c_idx[g] = '0; c_wdata[g] = '0; c_wmask[g] = '0;
      rdy[g] = 1'b1; ack_en[g] = 1'b1; flush[g] = 1'b1;
    end
    repeat (3) tick();
    rst = 1'b0;
    flush[0] = 1'b0;
    flush[1] = 1'b0;
    tick();
    test_reset();
    test_read();
    test_write_mask();
    test_empty_mask();
    test_outstanding();
    test_timeout();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
